// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the HD44780 bus engine.
//   state_t           - bus-cycle FSM states
//   CMD_*             - common HD44780 command bytes
//   *_DEF             - default bus timing in clk cycles (50 MHz)
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POLL_AS,
        POLL_PW,
        POLL_H,
        WR_AS,
        WR_PW,
        WR_H
    } state_t;

    localparam logic [7:0] CMD_CLEAR         = 8'h01;
    localparam logic [7:0] CMD_HOME          = 8'h02;
    localparam logic [7:0] CMD_ENTRY_INC     = 8'h06;
    localparam logic [7:0] CMD_DISP_ON_CUR   = 8'h0E;
    localparam logic [7:0] CMD_FUNC_SET_8B2L = 8'h38;

    localparam int          T_AS_DEF      = 4;
    localparam int          T_PW_DEF      = 12;
    localparam int          T_H_DEF       = 2;
    localparam logic [15:0] MAX_POLLS_DEF = 16'd50000;

    function automatic logic is_wr(input state_t s);
        return (s == WR_AS) || (s == WR_PW) || (s == WR_H);
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// lcd_phase_timer: loadable down-counter timing one bus phase.
//   clk, rst      - clock, async active-low reset
//   load/load_val - load (phase length - 1) on phase entry
//   tc            - terminal count: current cycle is the last of the phase
module lcd_phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               count <= '0;
        else if (load)          count <= load_val;
        else if (count != '0)   count <= count - 1'b1;
    end

    assign tc = (count == '0);

endmodule

// File: rtl/lcd_bus_cycle.sv
// lcd_bus_cycle: HD44780 bus engine. Accepts one byte per valid/ready
// handshake, polls the busy flag with read cycles until clear (unless
// req_nopoll), then performs one timed write cycle.
//   clk, rst                        - clock, async active-low reset
//   req_valid/req_ready             - request handshake
//   req_rs/req_data/req_nopoll      - request fields
//   done / err                      - one-cycle completion / poll-timeout pulses
//   addr_out                        - address counter from last poll read
//   rs_lcd/rw_lcd/en_lcd            - LCD control pins
//   data_out/data_oe/data_in        - LCD data bus (tristate built above)
module lcd_bus_cycle
    import lcd_pkg::*;
#(
    parameter int          T_AS      = T_AS_DEF,
    parameter int          T_PW      = T_PW_DEF,
    parameter int          T_H       = T_H_DEF,
    parameter logic [15:0] MAX_POLLS = MAX_POLLS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    input  logic       req_nopoll,
    output logic       done,
    output logic       err,
    output logic [6:0] addr_out,
    output logic       rs_lcd,
    output logic       rw_lcd,
    output logic       en_lcd,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] data_in
);

    localparam logic [15:0] AS_LD = 16'(T_AS - 1);
    localparam logic [15:0] PW_LD = 16'(T_PW - 1);
    localparam logic [15:0] H_LD  = 16'(T_H - 1);

    state_t      state, state_nxt;
    logic        tc, load, accept, done_nxt, err_nxt, bf;
    logic [15:0] load_val, poll_cnt, cnt_nxt, poll_inc;
    logic        cap_rs, wr_rs;
    logic [7:0]  cap_data, wr_data;

    lcd_phase_timer #(.W(16)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .tc       (tc)
    );

    // req_ready is only ever high while in IDLE
    assign accept   = req_valid && req_ready;
    assign poll_inc = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;
    // The accepting edge must already drive the new request onto the bus
    assign wr_rs    = accept ? req_rs   : cap_rs;
    assign wr_data  = accept ? req_data : cap_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_val  = AS_LD;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        cnt_nxt   = poll_cnt;
        case (state)
            IDLE: if (accept) begin
                cnt_nxt   = '0;
                load      = 1'b1;
                state_nxt = req_nopoll ? WR_AS : POLL_AS;
            end
            POLL_AS: if (tc) begin
                load = 1'b1; load_val = PW_LD; state_nxt = POLL_PW;
            end
            POLL_PW: if (tc) begin
                load = 1'b1; load_val = H_LD;  state_nxt = POLL_H;
            end
            POLL_H: if (tc) begin
                if (!bf) begin
                    load = 1'b1; state_nxt = WR_AS;
                end else begin
                    cnt_nxt = poll_inc;
                    if (poll_inc >= MAX_POLLS) begin
                        err_nxt = 1'b1; state_nxt = IDLE;
                    end else begin
                        load = 1'b1; state_nxt = POLL_AS;
                    end
                end
            end
            WR_AS: if (tc) begin
                load = 1'b1; load_val = PW_LD; state_nxt = WR_PW;
            end
            WR_PW: if (tc) begin
                load = 1'b1; load_val = H_LD;  state_nxt = WR_H;
            end
            WR_H: if (tc) begin
                done_nxt = 1'b1; state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from next state so every pin is a flop aligned with state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready <= 1'b0;
            en_lcd    <= 1'b0;
            rw_lcd    <= 1'b1;
            rs_lcd    <= 1'b0;
            data_oe   <= 1'b0;
            data_out  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            addr_out  <= '0;
            bf        <= 1'b0;
            poll_cnt  <= '0;
            cap_rs    <= 1'b0;
            cap_data  <= '0;
        end else begin
            req_ready <= (state_nxt == IDLE);
            en_lcd    <= (state_nxt == POLL_PW) || (state_nxt == WR_PW);
            rw_lcd    <= !is_wr(state_nxt);
            data_oe   <= is_wr(state_nxt);
            rs_lcd    <= is_wr(state_nxt) ? wr_rs   : 1'b0;
            data_out  <= is_wr(state_nxt) ? wr_data : 8'h00;
            done      <= done_nxt;
            err       <= err_nxt;
            poll_cnt  <= cnt_nxt;
            if (accept) begin
                cap_rs   <= req_rs;
                cap_data <= req_data;
            end
            // sampled on the edge that drops en_lcd of a read cycle
            if (state == POLL_PW && tc) begin
                bf       <= data_in[7];
                addr_out <= data_in[6:0];
            end
        end
    end

endmodule

// File: tb/tb_lcd_bus_cycle.sv
// tb_lcd_bus_cycle: directed checks of the HD44780 bus engine
// (defaults for phase timing, MAX_POLLS=4 to keep the timeout short).
module tb_lcd_bus_cycle;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0, req_rs = 1'b0, req_nopoll = 1'b0;
    logic [7:0] req_data = '0, data_in = '0;
    logic       req_ready, done, err, rs_lcd, rw_lcd, en_lcd, data_oe;
    logic [6:0] addr_out;
    logic [7:0] data_out;

    int n_vec = 0, n_miss = 0;

    // per-operation observations
    int         lat, n_rd, n_wr, rd_len, wr_len, gap_bad, bus_bad, n_done;
    logic       got_done, got_err, oe_seen, wr_r;
    logic [7:0] wr_d;
    logic [6:0] poll_addr;

    always #5 clk = ~clk;

    lcd_bus_cycle #(.MAX_POLLS(16'd4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rs     (req_rs),
        .req_data   (req_data),
        .req_nopoll (req_nopoll),
        .done       (done),
        .err        (err),
        .addr_out   (addr_out),
        .rs_lcd     (rs_lcd),
        .rw_lcd     (rw_lcd),
        .en_lcd     (en_lcd),
        .data_out   (data_out),
        .data_oe    (data_oe),
        .data_in    (data_in)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for ready, present a request, step over the accepting edge.
    task automatic issue(input logic rs, input logic [7:0] d, input logic np);
        int w;
        w = 0;
        while (!req_ready && w < 50) begin
            tick();
            w++;
        end
        chk("ready_before_issue", int'(req_ready), 1);
        req_valid  = 1'b1;
        req_rs     = rs;
        req_data   = d;
        req_nopoll = np;
        tick();
    endtask

    // Follow the bus after acceptance until done/err or budget expiry.
    // The first `busy` read cycles return BF=1.
    task automatic observe(input int busy, input int budget);
        logic en_q;
        int   last_rd;
        en_q = 1'b0; last_rd = -1;
        lat = -1; n_rd = 0; n_wr = 0; rd_len = 0; wr_len = 0; gap_bad = 0; bus_bad = 0;
        got_done = 1'b0; got_err = 1'b0; oe_seen = 1'b0; wr_r = 1'b0; wr_d = '0;
        for (int c = 1; c <= budget; c++) begin
            tick();
            if (en_lcd && !en_q) begin
                if (rw_lcd) begin
                    n_rd++;
                    if (last_rd >= 0 && c - last_rd != 18) gap_bad++;
                    last_rd = c;
                    data_in = {(n_rd <= busy), poll_addr};
                end else begin
                    n_wr++;
                    wr_d = data_out;
                    wr_r = rs_lcd;
                end
            end
            if (en_lcd) begin
                if (rw_lcd) rd_len++;
                else begin
                    wr_len++;
                    if (data_out !== wr_d || rs_lcd !== wr_r) bus_bad++;
                end
            end
            if (data_oe) oe_seen = 1'b1;
            if (data_oe === rw_lcd) bus_bad++;  // drive exactly when writing
            en_q = en_lcd;
            if (done || err) begin
                lat = c; got_done = done; got_err = err;
                break;
            end
        end
    endtask

    initial begin
        // ---- reset state
        repeat (3) tick();
        chk("rst_en",       int'(en_lcd),    0);
        chk("rst_rw",       int'(rw_lcd),    1);
        chk("rst_rs",       int'(rs_lcd),    0);
        chk("rst_oe",       int'(data_oe),   0);
        chk("rst_data_out", int'(data_out),  0);
        chk("rst_ready",    int'(req_ready), 0);
        chk("rst_done_err", int'({done, err}), 0);
        chk("rst_addr",     int'(addr_out),  0);
        rst = 1'b1;
        chk("ready_at_release", int'(req_ready), 0);
        tick();
        chk("ready_after_release", int'(req_ready), 1);

        // ---- nopoll command write, then change inputs after acceptance
        poll_addr = 7'h00;
        issue(1'b0, 8'h38, 1'b1);
        req_valid = 1'b0; req_data = 8'hFF; req_rs = 1'b1;
        observe(0, 60);
        chk("np_lat",     lat,         18);
        chk("np_done",    int'(got_done), 1);
        chk("np_rd",      n_rd,        0);
        chk("np_wr",      n_wr,        1);
        chk("np_wr_len",  wr_len,      12);
        chk("np_data",    int'(wr_d),  8'h38);
        chk("np_rs",      int'(wr_r),  0);
        chk("np_bus",     bus_bad,     0);
        chk("np_ready_on_done", int'(req_ready), 1);
        tick();
        chk("np_done_pulse", int'(done), 0);

        // ---- polled char write, BF=0 on first read
        poll_addr = 7'h05;
        issue(1'b1, 8'h50, 1'b0);
        req_valid = 1'b0; req_data = 8'h00;
        observe(0, 80);
        chk("p1_lat",    lat,            36);
        chk("p1_done",   int'(got_done), 1);
        chk("p1_rd",     n_rd,           1);
        chk("p1_rd_len", rd_len,         12);
        chk("p1_wr",     n_wr,           1);
        chk("p1_wr_len", wr_len,         12);
        chk("p1_data",   int'(wr_d),     8'h50);
        chk("p1_rs",     int'(wr_r),     1);
        chk("p1_addr",   int'(addr_out), 7'h05);
        chk("p1_bus",    bus_bad,        0);

        // ---- busy for three reads, then ready
        poll_addr = 7'h12;
        issue(1'b0, 8'h01, 1'b0);
        req_valid = 1'b0;
        observe(3, 150);
        chk("bz_lat",    lat,            90);
        chk("bz_done",   int'(got_done), 1);
        chk("bz_rd",     n_rd,           4);
        chk("bz_rd_len", rd_len,         48);
        chk("bz_gap",    gap_bad,        0);
        chk("bz_wr",     n_wr,           1);
        chk("bz_data",   int'(wr_d),     8'h01);
        chk("bz_addr",   int'(addr_out), 7'h12);
        chk("bz_bus",    bus_bad,        0);

        // ---- BF stuck at 1: abort after MAX_POLLS=4 reads
        poll_addr = 7'h33;
        issue(1'b1, 8'h41, 1'b0);
        req_valid = 1'b0;
        observe(1000, 150);
        chk("to_lat",   lat,            72);
        chk("to_err",   int'(got_err),  1);
        chk("to_done",  int'(got_done), 0);
        chk("to_rd",    n_rd,           4);
        chk("to_wr",    n_wr,           0);
        chk("to_oe",    int'(oe_seen),  0);
        chk("to_ready", int'(req_ready), 1);
        tick();
        chk("to_err_pulse", int'(err), 0);

        // ---- back-to-back "PR" with req_valid held
        issue(1'b1, 8'h50, 1'b1);
        observe(0, 60);
        chk("bb1_lat",  lat,           18);
        chk("bb1_data", int'(wr_d),    8'h50);
        chk("bb1_ready_on_done", int'(req_ready), 1);
        req_data = 8'h52;          // 'P' consumed; present 'R'
        tick();                    // accepted on the edge closing the done cycle
        chk("bb2_accept_no_gap", int'(req_ready), 0);
        req_valid = 1'b0; req_data = 8'h00;
        observe(0, 60);
        chk("bb2_lat",    lat,          18);
        chk("bb2_wr",     n_wr,         1);
        chk("bb2_wr_len", wr_len,       12);
        chk("bb2_data",   int'(wr_d),   8'h52);
        chk("bb2_rs",     int'(wr_r),   1);
        chk("bb2_bus",    bus_bad,      0);

        // ---- reset in the middle of the enable pulse
        issue(1'b0, 8'h0E, 1'b1);
        req_valid = 1'b0;
        repeat (8) tick();
        chk("mr_in_pulse", int'(en_lcd), 1);
        rst = 1'b0;
        #1;
        chk("mr_en",    int'(en_lcd),    0);
        chk("mr_rw",    int'(rw_lcd),    1);
        chk("mr_oe",    int'(data_oe),   0);
        chk("mr_ready", int'(req_ready), 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("mr_ready_after", int'(req_ready), 1);
        n_done = 0;
        for (int i = 0; i < 25; i++) begin
            if (done || err) n_done++;
            tick();
        end
        chk("mr_no_done", n_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
